// File: rtl/recon_luma4x4.sv
// 4x4 luma intra reconstruction: H.264 4x4 prediction from latched neighbours plus a
// streamed residual, clipped to 8 bits and emitted one pixel per accepted residual.
//
// state | meaning
// IDLE  | waiting for start; neighbours and mode latched on start
// RUN   | accepting residuals 0..15, one reconstructed pixel per acceptance
// DRAIN | residual 15 taken; waiting for pixel 15 to be accepted downstream
module recon_luma4x4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [63:0] toppixels,
    input  logic [39:0] leftpixels,
    input  logic        res_valid,
    input  logic [8:0]  res_data,
    output logic        res_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [3:0]  out_idx,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [2:0] MODE_V   = 3'd0;
    localparam logic [2:0] MODE_H   = 3'd1;
    localparam logic [2:0] MODE_DDL = 3'd2;
    localparam logic [2:0] MODE_DDR = 3'd3;
    localparam logic [2:0] MODE_VR  = 3'd4;
    localparam logic [2:0] MODE_HD  = 3'd5;
    localparam logic [2:0] MODE_VL  = 3'd6;
    localparam logic [2:0] MODE_HU  = 3'd7;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_mode;
    logic [63:0] r_top;
    logic [39:0] r_left;
    logic [3:0]  r_in_cnt;
    logic [3:0]  r_out_cnt;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [3:0]  r_out_idx;
    logic        r_done;

    logic        w_res_ready;
    logic        w_acc;
    logic        w_out_hs;
    logic        w_finish;
    logic [7:0]  w_nb [0:15];
    logic [3:0]  w_i0;
    logic [3:0]  w_i1;
    logic [3:0]  w_i2;
    logic        w_two_tap;
    logic [9:0]  w_f2;
    logic [9:0]  w_f3;
    logic [9:0]  w_pred;
    logic [9:0]  w_sum;
    logic [7:0]  w_recon;

    // Unified edge array: 0..2=L (HU extension), 3=K, 4=J, 5=I, 6=M, 7..14=A..H, 15=H.
    // Left row y sits at 5-y and top column x at 7+x, so every mode is a 3-tap window.
    always_comb begin
        w_nb[0] = r_left[39:32];
        w_nb[1] = r_left[39:32];
        w_nb[2] = r_left[39:32];
        w_nb[3] = r_left[31:24];
        w_nb[4] = r_left[23:16];
        w_nb[5] = r_left[15:8];
        w_nb[6] = r_left[7:0];
        for (int k = 0; k < 8; k++) begin
            w_nb[7+k] = r_top[8*k +: 8];
        end
        w_nb[15] = r_top[63:56];
    end

    // Tap selection for the current raster position; single-value modes use a==b==c.
    always_comb begin
        int x, y, s, z, i0, i1, i2;
        x = {30'd0, r_in_cnt[1:0]};
        y = {30'd0, r_in_cnt[3:2]};
        s = 0;
        z = 0;
        i0 = 6;
        i1 = 6;
        i2 = 6;
        w_two_tap = 1'b0;
        case (r_mode)
            MODE_V: begin
                i0 = 7 + x; i1 = i0; i2 = i0;
            end
            MODE_H: begin
                i0 = 5 - y; i1 = i0; i2 = i0;
            end
            MODE_DDL: begin
                s = x + y; i0 = 7 + s; i1 = 8 + s; i2 = 9 + s;
            end
            MODE_DDR: begin
                s = x - y; i0 = 5 + s; i1 = 6 + s; i2 = 7 + s;
            end
            MODE_VR: begin
                s = x - (y >> 1);
                z = 2 * x - y;
                if (z >= 0 && !z[0]) begin
                    w_two_tap = 1'b1; i0 = 6 + s; i1 = 7 + s; i2 = i1;
                end else if (z >= -1) begin
                    i0 = 5 + s; i1 = 6 + s; i2 = 7 + s;
                end else begin
                    i0 = 6 - y; i1 = 7 - y; i2 = 8 - y;
                end
            end
            MODE_HD: begin
                s = y - (x >> 1);
                z = 2 * y - x;
                if (z >= 0 && !z[0]) begin
                    w_two_tap = 1'b1; i0 = 6 - s; i1 = 5 - s; i2 = i1;
                end else if (z >= -1) begin
                    i0 = 7 - s; i1 = 6 - s; i2 = 5 - s;
                end else begin
                    i0 = 6 + x; i1 = 5 + x; i2 = 4 + x;
                end
            end
            MODE_VL: begin
                s = x + (y >> 1);
                w_two_tap = !y[0];
                i0 = 7 + s; i1 = 8 + s; i2 = y[0] ? 9 + s : i1;
            end
            MODE_HU: begin
                s = y + (x >> 1);
                z = x + 2 * y;
                if (z > 5) begin
                    i0 = 2; i1 = 2; i2 = 2;
                end else if (!z[0]) begin
                    w_two_tap = 1'b1; i0 = 5 - s; i1 = 4 - s; i2 = i1;
                end else begin
                    i0 = 5 - s; i1 = 4 - s; i2 = 3 - s;
                end
            end
            default: begin
                i0 = 6; i1 = 6; i2 = 6;
            end
        endcase
        w_i0 = 4'(i0);
        w_i1 = 4'(i1);
        w_i2 = 4'(i2);
    end

    assign w_f2   = {2'b00, w_nb[w_i0]} + {2'b00, w_nb[w_i1]} + 10'd1;
    assign w_f3   = {2'b00, w_nb[w_i0]} + {1'b0, w_nb[w_i1], 1'b0} + {2'b00, w_nb[w_i2]} + 10'd2;
    assign w_pred = w_two_tap ? (w_f2 >> 1) : (w_f3 >> 2);
    // pred is 0..255 and res is -256..255, so the 10-bit signed sum cannot overflow.
    assign w_sum  = w_pred + {res_data[8], res_data};
    assign w_recon = w_sum[9] ? 8'd0 : (w_sum[8] ? 8'd255 : w_sum[7:0]);

    assign w_acc    = res_valid && w_res_ready;
    assign w_out_hs = r_out_valid && out_ready;
    assign w_finish = (r_state == S_DRAIN) && w_out_hs && (r_out_cnt == 4'd15);

    always_comb begin
        w_state_nxt = r_state;
        w_res_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_res_ready = !r_out_valid || out_ready;
                if (res_valid && w_res_ready && r_in_cnt == 4'd15) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_finish) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 3'd0;
            r_top       <= 64'd0;
            r_left      <= 40'd0;
            r_in_cnt    <= 4'd0;
            r_out_cnt   <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_idx   <= 4'd0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            if (r_state == S_IDLE && start) begin
                r_mode    <= mode;
                r_top     <= toppixels;
                r_left    <= leftpixels;
                r_in_cnt  <= 4'd0;
                r_out_cnt <= 4'd0;
            end else begin
                if (w_acc) r_in_cnt <= r_in_cnt + 4'd1;
                if (w_out_hs) r_out_cnt <= r_out_cnt + 4'd1;
            end
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_recon;
                r_out_idx   <= r_in_cnt;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign res_ready = w_res_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_recon_luma4x4.sv
// Directed bench for recon_luma4x4: one task per scenario, hand-derived expected pixels.
module tb_recon_luma4x4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic [63:0] toppixels;
    logic [39:0] leftpixels;
    logic        res_valid;
    logic [8:0]  res_data;
    logic        res_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_idx;
    logic        out_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    recon_luma4x4 dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .toppixels(toppixels), .leftpixels(leftpixels),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass = 0;

    logic [8:0] tb_res [16];
    logic [7:0] got_data [16];
    logic [3:0] got_idx [16];
    int         got_cyc [16];
    int         n_out, done_cyc, done_cnt;
    bit         timeout;
    logic [7:0] st_data [8];
    logic [3:0] st_idx [8];
    logic       st_rr [8];
    int         st_n;

    localparam logic [63:0] TOP_V = {32'd0, 8'd40, 8'd30, 8'd20, 8'd10};

    // Drives one block and records every downstream handshake; no checking here.
    task automatic run_block(input logic [2:0] md, input logic [63:0] top, input logic [39:0] left,
                             input int bp_hold, input bit glitch);
        int k, cyc, bp, post;
        k = 0; cyc = 0; bp = 0; post = 0;
        n_out = 0; done_cnt = 0; done_cyc = -1; timeout = 0; st_n = 0;
        @(negedge clk);
        start = 1'b1; mode = md; toppixels = top; leftpixels = left;
        res_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        mode = md ^ 3'd1; toppixels = ~top; leftpixels = ~left;
        while (post < 3 && cyc < 200) begin
            out_ready = !(out_valid && n_out == 0 && bp < bp_hold);
            res_valid = (k < 16);
            res_data  = tb_res[(k < 16) ? k : 0];
            start     = glitch && (k == 5);
            #1;
            if (!out_ready) begin
                if (st_n < 8) begin
                    st_data[st_n] = out_data; st_idx[st_n] = out_idx; st_rr[st_n] = res_ready;
                end
                st_n++; bp++;
            end
            if (res_valid && res_ready) k++;
            if (out_valid && out_ready) begin
                if (n_out < 16) begin
                    got_data[n_out] = out_data; got_idx[n_out] = out_idx; got_cyc[n_out] = cyc;
                end
                n_out++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0) post++;
            @(negedge clk);
            cyc++;
        end
        if (done_cyc < 0) timeout = 1;
        res_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mode = 3'd2; res_valid = 1'b1; res_data = 9'd5;
        out_ready = 1'b1; toppixels = '1; leftpixels = '1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (res_ready !== 1'b0) $display("FAIL reset_res_ready got %b want 0", res_ready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (out_data !== 8'd0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
        n_checks++; if (out_idx !== 4'd0) $display("FAIL reset_out_idx got %0d want 0", out_idx); else n_pass++;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; res_valid = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (res_ready !== 1'b0) $display("FAIL idle_res_ready got %b want 0", res_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else n_pass++;
        res_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_no_consume got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_v_mode();
        for (int i = 0; i < 16; i++) tb_res[i] = 9'd5;
        run_block(3'd0, TOP_V, 40'hFF_FFFF_FFFF, 0, 1'b0);
        n_checks++; if (timeout) $display("FAIL v_timeout got no done within budget"); else n_pass++;
        n_checks++; if (n_out != 16) $display("FAIL v_count got %0d want 16", n_out); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got_data[i] !== 8'(15 + 10 * (i % 4))) $display("FAIL v_data[%0d] got %0d want %0d", i, got_data[i], 15 + 10 * (i % 4));
            else n_pass++;
            n_checks++; if (got_idx[i] !== 4'(i)) $display("FAIL v_idx[%0d] got %0d want %0d", i, got_idx[i], i); else n_pass++;
            n_checks++;
            if (got_cyc[i] != got_cyc[0] + i) $display("FAIL v_cycle[%0d] got %0d want %0d", i, got_cyc[i], got_cyc[0] + i);
            else n_pass++;
        end
        n_checks++; if (done_cyc != got_cyc[15] + 1) $display("FAIL v_done_cycle got %0d want %0d", done_cyc, got_cyc[15] + 1); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL v_done_pulses got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_h_mode();
        logic [7:0] exp_row [4];
        exp_row[0] = 8'd255; exp_row[1] = 8'd100; exp_row[2] = 8'd0; exp_row[3] = 8'd7;
        for (int i = 0; i < 16; i++) tb_res[i] = (i < 4) ? 9'd20 : ((i >= 8 && i < 12) ? 9'h1FD : 9'd0);
        run_block(3'd1, 64'h1234_5678_9ABC_DEF0, {8'd7, 8'd0, 8'd100, 8'd250, 8'd33}, 0, 1'b0);
        n_checks++; if (n_out != 16) $display("FAIL h_count got %0d want 16", n_out); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got_data[i] !== exp_row[i / 4]) $display("FAIL h_data[%0d] got %0d want %0d", i, got_data[i], exp_row[i / 4]);
            else n_pass++;
        end
        n_checks++; if (done_cnt != 1) $display("FAIL h_done_pulses got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_ddr();
        for (int i = 0; i < 16; i++) tb_res[i] = 9'd0;
        run_block(3'd3, {32'h0102_0304, {4{8'd128}}}, {5{8'd128}}, 0, 1'b0);
        n_checks++; if (n_out != 16) $display("FAIL ddr_count got %0d want 16", n_out); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (got_data[i] !== 8'd128) $display("FAIL ddr_data[%0d] got %0d want 128", i, got_data[i]); else n_pass++;
        end
    endtask

    task automatic test_hu();
        for (int i = 0; i < 16; i++) tb_res[i] = 9'd0;
        run_block(3'd7, 64'd0, {{4{8'd60}}, 8'd0}, 0, 1'b0);
        n_checks++; if (n_out != 16) $display("FAIL hu_count got %0d want 16", n_out); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (got_data[i] !== 8'd60) $display("FAIL hu_data[%0d] got %0d want 60", i, got_data[i]); else n_pass++;
        end
    endtask

    task automatic test_ddl();
        int e;
        for (int i = 0; i < 16; i++) tb_res[i] = 9'd0;
        run_block(3'd2, {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0}, 40'd0, 0, 1'b0);
        n_checks++; if (n_out != 16) $display("FAIL ddl_count got %0d want 16", n_out); else n_pass++;
        // Linear ramp: the 3-tap filter returns the centre tap, except at the H-padded corner.
        for (int i = 0; i < 16; i++) begin
            e = (i == 15) ? 68 : 10 * ((i / 4) + (i % 4) + 1);
            n_checks++; if (got_data[i] !== 8'(e)) $display("FAIL ddl_data[%0d] got %0d want %0d", i, got_data[i], e); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) tb_res[i] = 9'd5;
        run_block(3'd0, TOP_V, 40'd0, 3, 1'b0);
        n_checks++; if (st_n != 3) $display("FAIL bp_stall_cycles got %0d want 3", st_n); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (st_data[i] !== 8'd15) $display("FAIL bp_hold_data[%0d] got %0d want 15", i, st_data[i]); else n_pass++;
            n_checks++; if (st_idx[i] !== 4'd0) $display("FAIL bp_hold_idx[%0d] got %0d want 0", i, st_idx[i]); else n_pass++;
            n_checks++; if (st_rr[i] !== 1'b0) $display("FAIL bp_res_ready[%0d] got %b want 0", i, st_rr[i]); else n_pass++;
        end
        n_checks++; if (n_out != 16) $display("FAIL bp_count got %0d want 16", n_out); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (got_idx[i] !== 4'(i)) $display("FAIL bp_idx[%0d] got %0d want %0d", i, got_idx[i], i); else n_pass++;
        end
        n_checks++; if (done_cnt != 1) $display("FAIL bp_done_pulses got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_reset_midblock();
        int k, cyc;
        @(negedge clk);
        start = 1'b1; mode = 3'd0; toppixels = TOP_V; leftpixels = 40'd0; res_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0; cyc = 0;
        while (k < 7 && cyc < 50) begin
            res_valid = 1'b1; res_data = 9'd5;
            #1;
            if (res_ready) k++;
            @(negedge clk);
            cyc++;
        end
        #1;
        n_checks++; if (k != 7) $display("FAIL mid_accepted got %0d want 7", k); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else n_pass++;
        reset = 1'b1; start = 1'b1; mode = 3'd1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_idx !== 4'd0) $display("FAIL mid_reset_out_idx got %0d want 0", out_idx); else n_pass++;
        reset = 1'b0; start = 1'b0; res_valid = 1'b0;
        for (int i = 0; i < 16; i++) tb_res[i] = 9'd5;
        run_block(3'd0, TOP_V, 40'hAA_BBCC_DDEE, 0, 1'b1);
        n_checks++; if (timeout) $display("FAIL fresh_timeout got no done within budget"); else n_pass++;
        n_checks++; if (n_out != 16) $display("FAIL fresh_count got %0d want 16", n_out); else n_pass++;
        n_checks++; if (got_idx[0] !== 4'd0) $display("FAIL fresh_first_idx got %0d want 0", got_idx[0]); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got_data[i] !== 8'(15 + 10 * (i % 4))) $display("FAIL fresh_data[%0d] got %0d want %0d", i, got_data[i], 15 + 10 * (i % 4));
            else n_pass++;
        end
        n_checks++; if (done_cyc != got_cyc[15] + 1) $display("FAIL fresh_done_cycle got %0d want %0d", done_cyc, got_cyc[15] + 1); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL fresh_done_pulses got %0d want 1", done_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_v_mode();
        test_h_mode();
        test_ddr();
        test_hu();
        test_ddl();
        test_backpressure();
        test_reset_midblock();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/recon_luma4x4.md
RECON_LUMA4X4 -- requirements
Module: recon_luma4x4

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: one-cycle request to begin a 4x4 block; sampled only in IDLE.
REQ-004 The block SHALL have the port mode, input, 3 bits, sampled with start: 0=V, 1=H, 2=DDL, 3=DDR, 4=VR, 5=HD, 6=VL, 7=HU.
REQ-005 The block SHALL have the port toppixels, input, 64 bits, sampled with start: A at [7:0] through H at [63:56].
REQ-006 The block SHALL have the port leftpixels, input, 40 bits, sampled with start: M at [7:0], I at [15:8], J, K, L at [39:32].
REQ-007 The block SHALL have the port res_valid, input, 1 bit: a residual sample is present.
REQ-008 The block SHALL have the port res_data, input, 9 bits: signed two's-complement residual, raster order, index 0..15 = row*4+col.
REQ-009 The block SHALL have the port res_ready, output, 1 bit: the block accepts a residual this cycle.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: a reconstructed pixel is present.
REQ-011 The block SHALL have the port out_data, output, 8 bits: the reconstructed pixel.
REQ-012 The block SHALL have the port out_idx, output, 4 bits: raster index of out_data.
REQ-013 The block SHALL have the port out_ready, input, 1 bit: the downstream accepts out_data.
REQ-014 The block SHALL have the port busy, output, 1 bit: high in every state other than IDLE.
REQ-015 The block SHALL have the port done, output, 1 bit: one-cycle pulse when the 16th pixel is accepted downstream.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-017 In IDLE, start=1 SHALL register mode and the 13 neighbours and move the FSM to RUN on the next cycle; the input counter and the output counter SHALL be cleared.
REQ-018 In any state other than IDLE, start SHALL be ignored, and the registered neighbours and mode SHALL remain unchanged.
REQ-019 res_ready SHALL be high only in RUN and only when (!out_valid || out_ready).
REQ-020 A residual SHALL be accepted when res_valid && res_ready.
REQ-021 On acceptance of residual n, out_data, out_idx=n and out_valid=1 SHALL be registered on the same edge, giving one cycle of latency.
REQ-022 While out_valid=1 && out_ready=0, out_valid, out_data and out_idx SHALL hold stable.
REQ-023 When the output handshake completes and no new residual is accepted on that edge, out_valid SHALL clear.
REQ-024 Accept-and-emit in the same cycle SHALL sustain 1 pixel/cycle throughput.
REQ-025 Acceptance of residual 15 SHALL move the FSM from RUN to DRAIN.
REQ-026 In DRAIN, the output handshake of index 15 SHALL pulse done and return the FSM to IDLE in the same cycle; done SHALL be registered, asserting on the cycle after that handshake.
REQ-027 Prediction pred[n] SHALL be computed combinationally from the registered mode and neighbours using the H.264 4x4 luma equations, with round-to-nearest ((a+2b+c+2)>>2 and (a+b+1)>>1) and 10-bit unsigned intermediates.
REQ-028 V mode SHALL use pred=top[col].
REQ-029 H mode SHALL use pred=left[row], where I=row 0.
REQ-030 DDL mode SHALL use E..H.
REQ-031 DDR, VR and HD modes SHALL use M.
REQ-032 In HU mode, every position with zHU>5 SHALL take the value L.
REQ-033 The sum SHALL be formed as signed 10-bit pred + res_data (sign-extended) and clipped to 0..255: a sum below 0 SHALL give 0, and a sum above 255 SHALL give 255.
REQ-034 res_valid in IDLE or DRAIN SHALL be ignored, and no residual SHALL be consumed.
REQ-035 The counters SHALL be 4-bit; wrap from 15 to 0 SHALL occur only on a state exit and never mid-block.

Reset
REQ-036 While reset=1, the FSM SHALL be IDLE and both counters SHALL be 0.
REQ-037 While reset=1, out_valid, res_ready, busy and done SHALL be 0.
REQ-038 While reset=1, out_data and out_idx SHALL be 0.
REQ-039 Reset SHALL take priority over start and over both handshakes.
REQ-040 Reset asserted mid-block SHALL abort it; the partial block SHALL not be resumed, and the next start SHALL begin a fresh block.
REQ-041 The stored neighbours and mode SHALL reset to 0.

Verification
REQ-042 The bench SHALL cover V mode with A..D=10,20,30,40, all res=+5 and out_ready=1: the outputs SHALL be 15,25,35,45 repeated for 4 rows, idx 0..15 on consecutive cycles, and done one cycle after idx 15.
REQ-043 The bench SHALL cover H mode with I..L=250,100,0,7 and res row0=+20, row2=-3, others 0: row0 SHALL be 255 (clip high), row1 100, row2 0 (clip low), and row3 7.
REQ-044 The bench SHALL cover DDR mode with M=128, A..D=I..L=128 and res=0: all 16 outputs SHALL be 128.
REQ-045 The bench SHALL cover HU mode with I=J=K=L=60 and res=0: all outputs SHALL be 60; it SHALL also cover DDL mode with A..H=0..70 step 10 and res=0, where idx15 SHALL be (G+3H+2)>>2=68.
REQ-046 The bench SHALL cover backpressure by holding out_ready=0 for 3 cycles after the first output: out_data and out_idx SHALL stay stable, res_ready SHALL be 0 throughout, and no residual SHALL be lost (16 outputs total).
REQ-047 The bench SHALL cover reset after 7 accepted residuals, followed by start in V mode: out_idx SHALL restart at 0, done SHALL follow exactly 16 outputs, and start asserted during RUN SHALL be ignored (the mode SHALL be unchanged).
